// File: rtl/pq_issue_ctrl.sv
// Issue controller in front of the register_tree priority queue: paces enqueue/dequeue/replace
// requests into single-cycle tree strobes, tracks occupancy and returns removed root values.
module pq_issue_ctrl #(
    parameter int unsigned QUEUE_SIZE = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ENQ_GAP    = $clog2(QUEUE_SIZE) + 3,
    parameter int unsigned DEQ_GAP    = 3
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [1:0]                    s_op,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          pq_wrt,
    output logic                          pq_read,
    output logic [DATA_WIDTH-1:0]         pq_data,
    input  logic                          pq_full,
    input  logic                          pq_empty,
    input  logic [DATA_WIDTH-1:0]         pq_root,
    output logic [$clog2(QUEUE_SIZE):0]   o_count,
    output logic                          o_err
);

    localparam int unsigned CW     = $clog2(QUEUE_SIZE) + 1;
    localparam int unsigned MAXGAP = (ENQ_GAP > DEQ_GAP) ? ENQ_GAP : DEQ_GAP;
    localparam int unsigned GW     = (MAXGAP > 2) ? $clog2(MAXGAP) : 1;
    localparam logic [1:0]  OP_ENQ = 2'b00;
    localparam logic [1:0]  OP_DEQ = 2'b01;
    localparam logic [1:0]  OP_REP = 2'b10;
    localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                r_state, w_state_nxt;
    logic [GW-1:0]         r_cnt, w_cnt_nxt;
    logic                  r_is_enq, w_is_enq_nxt;
    logic                  r_s_ready, w_s_ready_nxt;
    logic                  r_pq_wrt, w_pq_wrt_nxt;
    logic                  r_pq_read, w_pq_read_nxt;
    logic [DATA_WIDTH-1:0] r_pq_data, w_pq_data_nxt;
    logic                  r_m_valid, w_m_valid_nxt;
    logic [DATA_WIDTH-1:0] r_m_data, w_m_data_nxt;
    logic [CW-1:0]         r_count, w_count_nxt;
    logic                  r_err, w_err_nxt;
    logic                  w_accept, w_enq_ok, w_deq_ok;

    // Tracked count is authoritative; the tree flags only add a second veto.
    assign w_accept = s_valid && r_s_ready;
    assign w_enq_ok = (r_count != FULL_CNT) && !pq_full;
    assign w_deq_ok = (r_count != '0) && !pq_empty;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_is_enq_nxt  = r_is_enq;
        w_pq_wrt_nxt  = 1'b0;
        w_pq_read_nxt = 1'b0;
        w_pq_data_nxt = r_pq_data;
        w_m_valid_nxt = r_m_valid && !m_ready;
        w_m_data_nxt  = r_m_data;
        w_count_nxt   = r_count;
        w_err_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (s_op == OP_ENQ && w_enq_ok) begin
                        w_state_nxt   = S_ISSUE;
                        w_is_enq_nxt  = 1'b1;
                        w_pq_wrt_nxt  = 1'b1;
                        w_pq_data_nxt = s_data;
                        w_count_nxt   = r_count + CW'(1);
                    end else if ((s_op == OP_DEQ || s_op == OP_REP) && w_deq_ok) begin
                        w_state_nxt   = S_ISSUE;
                        w_is_enq_nxt  = 1'b0;
                        w_pq_read_nxt = 1'b1;
                        w_m_valid_nxt = 1'b1;
                        w_m_data_nxt  = pq_root;
                        if (s_op == OP_REP) begin
                            w_pq_wrt_nxt  = 1'b1;
                            w_pq_data_nxt = s_data;
                        end else begin
                            w_count_nxt = r_count - CW'(1);
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                // Counter holds gap-1 so WAIT lasts exactly gap cycles.
                if ((r_is_enq ? ENQ_GAP : DEQ_GAP) == 0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = r_is_enq ? GW'(ENQ_GAP - 1) : GW'(DEQ_GAP - 1);
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - GW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_s_ready_nxt = (w_state_nxt == S_IDLE) && !w_m_valid_nxt;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_is_enq  <= 1'b0;
            r_s_ready <= 1'b0;
            r_pq_wrt  <= 1'b0;
            r_pq_read <= 1'b0;
            r_pq_data <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_is_enq  <= w_is_enq_nxt;
            r_s_ready <= w_s_ready_nxt;
            r_pq_wrt  <= w_pq_wrt_nxt;
            r_pq_read <= w_pq_read_nxt;
            r_pq_data <= w_pq_data_nxt;
            r_m_valid <= w_m_valid_nxt;
            r_m_data  <= w_m_data_nxt;
            r_count   <= w_count_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign s_ready = r_s_ready;
    assign pq_wrt  = r_pq_wrt;
    assign pq_read = r_pq_read;
    assign pq_data = r_pq_data;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign o_count = r_count;
    assign o_err   = r_err;

endmodule

// File: tb/tb_pq_issue_ctrl.sv
// Bench for pq_issue_ctrl: a behavioural max-queue stands in for the tree, a separate
// reference queue predicts results, occupancy, error pulses and ready timing.
module tb_pq_issue_ctrl;

    logic        CLK;
    logic        RST;
    logic        s_valid;
    logic        s_ready;
    logic [1:0]  s_op;
    logic [15:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        pq_wrt;
    logic        pq_read;
    logic [15:0] pq_data;
    logic        pq_full;
    logic        pq_empty;
    logic [15:0] pq_root;
    logic [4:0]  o_count;
    logic        o_err;

    int checks   = 0;
    int failures = 0;
    int ref_q[$];
    logic force_full  = 1'b0;
    logic force_empty = 1'b0;

    pq_issue_ctrl dut (
        .CLK(CLK), .RST(RST),
        .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .pq_wrt(pq_wrt), .pq_read(pq_read), .pq_data(pq_data),
        .pq_full(pq_full), .pq_empty(pq_empty), .pq_root(pq_root),
        .o_count(o_count), .o_err(o_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stand-in tree: unordered storage, root is the running maximum.
    logic [15:0] tree_mem [16];
    logic [4:0]  tree_n;
    logic [3:0]  root_idx;
    logic [4:0]  tree_last;

    always_comb begin
        root_idx = 4'd0;
        for (int i = 1; i < 16; i++)
            if (5'(i) < tree_n && tree_mem[4'(i)] > tree_mem[root_idx]) root_idx = 4'(i);
    end
    assign tree_last = tree_n - 5'd1;
    assign pq_root   = (tree_n != 5'd0) ? tree_mem[root_idx] : 16'd0;
    assign pq_full   = (tree_n == 5'd16) || force_full;
    assign pq_empty  = (tree_n == 5'd0) || force_empty;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            tree_n <= 5'd0;
        end else if (pq_wrt && pq_read) begin
            tree_mem[root_idx] <= pq_data;
        end else if (pq_wrt && tree_n < 5'd16) begin
            tree_mem[tree_n[3:0]] <= pq_data;
            tree_n <= tree_n + 5'd1;
        end else if (pq_read && tree_n != 5'd0) begin
            tree_mem[root_idx] <= tree_mem[tree_last[3:0]];
            tree_n <= tree_n - 5'd1;
        end
    end

    function automatic int qmax_idx(input int q[$]);
        int b = 0;
        for (int i = 1; i < q.size(); i++)
            if (q[i] > q[b]) b = i;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!s_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("req_ready", 32'(s_ready), 32'd1);
    endtask

    // One request with m_ready held high; predicts everything from ref_q.
    task automatic do_op(input logic [1:0] op, input logic [15:0] d);
        bit legal;
        bit is_wr;
        bit is_rd;
        int exp_root;
        int n;
        m_ready = 1'b1;
        wait_ready();
        case (op)
            2'd0:    legal = (ref_q.size() < 16) && !force_full;
            2'd1,
            2'd2:    legal = (ref_q.size() > 0) && !force_empty;
            default: legal = 1'b0;
        endcase
        is_wr    = legal && (op == 2'd0 || op == 2'd2);
        is_rd    = legal && (op == 2'd1 || op == 2'd2);
        exp_root = (ref_q.size() > 0) ? ref_q[qmax_idx(ref_q)] : 0;
        s_valid = 1'b1;
        s_op    = op;
        s_data  = d;
        @(posedge CLK);
        @(negedge CLK);
        s_valid = 1'b0;
        if (is_rd) ref_q.delete(qmax_idx(ref_q));
        if (is_wr) ref_q.push_back(int'(d));
        chk("err_pulse", 32'(o_err), 32'(!legal));
        chk("wrt_pulse", 32'(pq_wrt), 32'(is_wr));
        chk("read_pulse", 32'(pq_read), 32'(is_rd));
        if (is_wr) chk("pq_data", 32'(pq_data), 32'(d));
        chk("m_valid", 32'(m_valid), 32'(is_rd));
        if (is_rd) chk("m_data", 32'(m_data), 32'(exp_root));
        chk("count", 32'(o_count), 32'(ref_q.size()));
        chk("ready_k1", 32'(s_ready), 32'(!legal));
        @(negedge CLK);
        chk("wrt_drop", 32'(pq_wrt), 32'd0);
        chk("read_drop", 32'(pq_read), 32'd0);
        chk("err_drop", 32'(o_err), 32'd0);
        chk("m_valid_drop", 32'(m_valid), 32'd0);
        if (legal) begin
            n = 1;
            while (!s_ready && n < 60) begin
                n++;
                @(negedge CLK);
            end
            chk("ready_low_cycles", 32'(n), (op == 2'd0) ? 32'd8 : 32'd4);
        end
    endtask

    initial begin
        int exp_root;
        RST = 1'b1;
        s_valid = 1'b0;
        s_op = 2'd0;
        s_data = 16'd0;
        m_ready = 1'b0;

        // Reset for three cycles; everything low/zero.
        repeat (3) begin
            @(negedge CLK);
            chk("rst_s_ready", 32'(s_ready), 32'd0);
        end
        chk("rst_pq_wrt", 32'(pq_wrt), 32'd0);
        chk("rst_pq_read", 32'(pq_read), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_o_err", 32'(o_err), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_pq_data", 32'(pq_data), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        chk("release_s_ready", 32'(s_ready), 32'd1);
        chk("release_count", 32'(o_count), 32'd0);

        // Directed sequence: enqueue, dequeue, replace.
        do_op(2'd0, 16'd5);
        do_op(2'd0, 16'd900);
        do_op(2'd0, 16'd42);
        chk("count_after_enq", 32'(o_count), 32'd3);
        do_op(2'd1, 16'd0);
        do_op(2'd1, 16'd0);
        chk("count_after_deq", 32'(o_count), 32'd1);
        do_op(2'd2, 16'd1000);
        do_op(2'd1, 16'd0);

        // Fill to capacity, overflow, drain, underflow.
        repeat (16) do_op(2'd0, 16'($urandom_range(0, 65535)));
        do_op(2'd0, 16'd7);
        chk("count_full", 32'(o_count), 32'd16);
        repeat (16) do_op(2'd1, 16'd0);
        do_op(2'd1, 16'd0);
        do_op(2'd2, 16'd123);
        chk("count_empty", 32'(o_count), 32'd0);

        // Tree flags veto even when the tracked count would allow the op.
        do_op(2'd0, 16'd77);
        force_full = 1'b1;
        do_op(2'd0, 16'd78);
        force_full = 1'b0;
        force_empty = 1'b1;
        do_op(2'd1, 16'd0);
        force_empty = 1'b0;

        // Random mix including the reserved opcode.
        repeat (40) begin
            int r;
            r = int'($urandom_range(0, 9));
            do_op((r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3,
                  16'($urandom_range(0, 65535)));
        end

        // Backpressure: result held, no new requests until consumed.
        if (ref_q.size() == 0) do_op(2'd0, 16'd321);
        wait_ready();
        exp_root = ref_q[qmax_idx(ref_q)];
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_op = 2'd1;
        @(posedge CLK);
        @(negedge CLK);
        s_valid = 1'b0;
        ref_q.delete(qmax_idx(ref_q));
        repeat (20) begin
            chk("bp_m_valid", 32'(m_valid), 32'd1);
            chk("bp_m_data", 32'(m_data), 32'(exp_root));
            chk("bp_s_ready", 32'(s_ready), 32'd0);
            @(negedge CLK);
        end
        m_ready = 1'b1;
        @(negedge CLK);
        chk("bp_m_valid_clear", 32'(m_valid), 32'd0);
        chk("bp_s_ready_back", 32'(s_ready), 32'd1);
        chk("bp_count", 32'(o_count), 32'(ref_q.size()));

        // Reset during the issue cycle cuts the pulse and clears state.
        wait_ready();
        s_valid = 1'b1;
        s_op = 2'd0;
        s_data = 16'd555;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        s_valid = 1'b0;
        #1;
        chk("midrst_wrt", 32'(pq_wrt), 32'd0);
        chk("midrst_count", 32'(o_count), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        ref_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_ready", 32'(s_ready), 32'd1);
        do_op(2'd0, 16'd9);
        do_op(2'd1, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
